aggr_path_sched: RTL
====================

// Module: aggr_path_sched
// PURPOSE
//  Sequencer for one SGBM 1-D path-aggregation lane. Per line it walks pixels 0..width-1 and, per pixel,
//  disparities 0..D-1. For each disparity it reads the matching cost C(p,d) from the cost buffer and computes
//  Lr(p,d) = sat(C + min(Lp[d], Lp[d-1]+P1, Lp[d+1]+P1, minLp+P2) - minLp) with a saturating add.
//  It streams each Lr to the sum-of-paths stage over a valid/ready port. Sits between cost RAM and path summer.
// PARAMETERS
//  D      64  disparities per pixel (power of 2, >=4)
//  DW     8   cost/result width; saturation ceiling = 2^DW-1
//  WW     12  width of the width/pixel counter
//  P1     2   small-step penalty
//  P2     32  large-step penalty
// PORTS
//  clk           in   1            rising-edge clock
//  rst           in   1            synchronous active-high reset
//  start         in   1            1-cycle pulse: begin line; sampled only in IDLE
//  width         in   WW           pixels in line; sampled on accepted start
//  busy          out  1            high from cycle after accepted start until done
//  done          out  1            1-cycle pulse after last result handshake
//  cost_rd_en    out  1            cost RAM read strobe
//  cost_rd_addr  out  WW+log2(D)   = pix*D + d
//  cost_rd_data  in   DW           C(p,d), valid exactly 1 cycle after cost_rd_en
//  out_valid     out  1            result valid
//  out_ready     in   1            downstream accept
//  out_cost      out  DW           Lr(p,d)
//  out_disp      out  log2(D)      d of out_cost
//  out_last      out  1            high with d=D-1 of pixel width-1
// BEHAVIOUR
//  Reset: every output 0 (busy, done, cost_rd_en, cost_rd_addr, out_valid, out_cost, out_disp, out_last).
//   Counters return to 0; FSM goes to IDLE. Lp contents are don't-care.
//  FSM: IDLE -> READ -> CALC -> OUT -> (READ | FIN) ; FIN -> IDLE.
//   IDLE: on start, latch width, clear pix/d. width=0 -> FIN directly (no reads, no output), else READ.
//   READ: cost_rd_en=1 for exactly this cycle, addr=pix*D+d. Always -> CALC.
//   CALC: capture cost_rd_data and compute Lr. Register out_cost/out_disp/out_last; out_valid=1 next cycle. -> OUT.
//   OUT: hold out_valid and all out_* stable until out_valid&&out_ready. On handshake, write Lr into Lp[d]
//    and fold it into the running min. Then: d<D-1 -> d++, READ.
//    d=D-1 && pix<width-1 -> minLp<=running min, reset running min, d=0, pix++, READ.
//    else -> FIN.
//   FIN: done=1 for one cycle, busy=0 from the next cycle. -> IDLE.
//  Throughput: 3 cycles per result minimum; no new cost_rd_en while out_valid&&!out_ready.
//  First pixel (pix=0): Lr = C unchanged, no penalty terms.
//  Boundaries: d=0 omits the Lp[d-1] term; d=D-1 omits the Lp[d+1] term.
//  Lp[d-1] must be the previous pixel's value. Preserve the old Lp[d-1] before it is overwritten
//   (hold register); never use the current pixel's Lr[d-1].
//  Arithmetic: unsigned, DW+3 bits internal. Penalty terms are never truncated.
//   Result = C + min_term - minLp. min_term >= minLp always, so no underflow.
//   Clamp to 2^DW-1 when the sum exceeds it.
//  start while busy: ignored, no effect on state or latched width.
//  rst mid-line: next cycle IDLE, all outputs 0, no done pulse, in-flight read data discarded.
// TESTING  (D=4, DW=8, P1=2, P2=32 unless stated)
//  1 Hold rst 3 cycles mid-traffic -> all outputs 0 the cycle after; busy 0; no done.
//  2 width=1, C=[10,20,30,40], out_ready=1 -> out_cost 10,20,30,40, disp 0..3.
//    out_last with the 4th result; done 1 cycle after; exactly 4 cost_rd_en, addr 0..3.
//  3 width=2, pix0 C=[10,20,30,40], pix1 C=[0,0,0,0] -> pix1 out_cost=[0,2,12,22];
//    rd addr 4..7 for pix1.
//  4 Saturation: pix0 C=[0,255,255,255], pix1 C=[255,255,255,255] -> pix1 out_cost=[255,255,255,255];
//    d1 pre-clamp value 257 clamps to 255.
//  5 Backpressure: drop out_ready 5 cycles while out_valid -> out_* stable, no cost_rd_en;
//    resumes 1 cycle after accept.
//  6 start pulses during busy, then width=0 start -> busy lines unaffected.
//    width=0 gives done with zero reads and zero outputs.

Source files
------------

// File: rtl/aggr_path_sched.sv
// SGBM 1-D path-aggregation lane sequencer.
// Walks pixel x disparity for one line, reads C(p,d) from the cost RAM,
// computes the penalised path cost Lr(p,d) and streams it over valid/ready.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; width latched on accepted start
// READ  | one-cycle cost RAM read strobe for (pix,d)
// CALC  | cost data returns; Lr computed and registered onto out_*
// OUT   | out_valid held until accepted; Lp/min bookkeeping on handshake
// FIN   | one-cycle done pulse, then back to IDLE
module aggr_path_sched #(
  parameter int D  = 64,
  parameter int DW = 8,
  parameter int WW = 12,
  parameter int P1 = 2,
  parameter int P2 = 32,
  localparam int DL = $clog2(D)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WW-1:0]    width,
  output logic             busy,
  output logic             done,
  output logic             cost_rd_en,
  output logic [WW+DL-1:0] cost_rd_addr,
  input  logic [DW-1:0]    cost_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_cost,
  output logic [DL-1:0]    out_disp,
  output logic             out_last
);

  localparam int IW = DW + 3;
  localparam logic [IW-1:0] SAT   = {3'b000, {DW{1'b1}}};
  localparam logic [IW-1:0] P1_I  = IW'(P1);
  localparam logic [IW-1:0] P2_I  = IW'(P2);
  localparam logic [IW-1:0] NOTRM = '1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_OUT, S_FIN} state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   width_q, pix;
  logic [DL-1:0]   d, dn;
  logic [DW-1:0]   lp [D];
  logic [DW-1:0]   hold, minlp, runmin;
  logic            last_d, last_pix;
  logic [IW-1:0]   t_lo, t_hi, t_far, min_t, sum;
  logic [DW-1:0]   lr;

  function automatic logic [IW-1:0] min2(input logic [IW-1:0] a, input logic [IW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign last_d   = (d == DL'(D - 1));
  assign last_pix = (pix == width_q - 1'b1);
  assign dn       = d + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and strobe outputs
  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    done         = 1'b0;
    cost_rd_en   = 1'b0;
    cost_rd_addr = '0;
    out_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (width == '0) ? S_FIN : S_READ;
      end
      S_READ: begin
        busy         = 1'b1;
        cost_rd_en   = 1'b1;
        cost_rd_addr = {pix, d};
        state_nx     = S_CALC;
      end
      S_CALC: begin
        busy     = 1'b1;
        state_nx = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = (last_d && last_pix) ? S_FIN : S_READ;
      end
      S_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Lr = sat(C + min(Lp[d], Lp[d-1]+P1, Lp[d+1]+P1, minLp+P2) - minLp).
  // Lp[d-1] comes from hold, since lp[d-1] already carries this pixel's result.
  always_comb begin
    t_lo  = (d == '0) ? NOTRM : IW'(hold) + P1_I;
    t_hi  = last_d ? NOTRM : IW'(lp[dn]) + P1_I;
    t_far = IW'(minlp) + P2_I;
    min_t = min2(min2(IW'(lp[d]), t_lo), min2(t_hi, t_far));
    if (pix == '0) sum = IW'(cost_rd_data);
    else           sum = IW'(cost_rd_data) + min_t - IW'(minlp);
    lr = (sum > SAT) ? {DW{1'b1}} : sum[DW-1:0];
  end

  // Counters, minimum tracking and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q  <= '0;
      pix      <= '0;
      d        <= '0;
      hold     <= '0;
      minlp    <= '0;
      runmin   <= '1;
      out_cost <= '0;
      out_disp <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            width_q <= width;
            pix     <= '0;
            d       <= '0;
            runmin  <= '1;
          end
        end
        S_CALC: begin
          out_cost <= lr;
          out_disp <= d;
          out_last <= last_d && last_pix;
        end
        S_OUT: begin
          if (out_ready) begin
            hold <= lp[d];
            if (last_d) begin
              d      <= '0;
              pix    <= pix + 1'b1;
              minlp  <= (out_cost < runmin) ? out_cost : runmin;
              runmin <= '1;
            end else begin
              d      <= dn;
              runmin <= (out_cost < runmin) ? out_cost : runmin;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Previous-pixel path cost store; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (state == S_OUT && out_ready) lp[d] <= out_cost;
  end

endmodule
